// File: rtl/rr_priority_arbiter_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority arbiter.
// Holds the mode and state encodings plus the modular decrement used for the rotation pointer.
package arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;

    // (k-1) mod n, never landing on codes >= n when n is not a power of two
    function automatic int dec_mod(input int k, input int n);
        dec_mod = (k == 0) ? (n - 1) : (k - 1);
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational MSB-first priority picker: reports the highest set bit of req.
// This is the N-wide generalisation of the original 8-bit priority encoder.
module prio_pick #(
    parameter  int N  = 8,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          hit
);

    // Ascending scan so the last (highest) set bit overwrites lower ones
    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = IW'(i);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_priority_arbiter.sv
// N-way arbiter with selectable fixed / round-robin priority and a registered,
// sticky grant held until the shared resource acknowledges it.
module rr_priority_arbiter
    import arb_pkg::*;
#(
    parameter  int N  = 8,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mode,
    input  logic [N-1:0]  req,
    input  logic          gnt_ack,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx,
    output logic [N-1:0]  gnt_onehot,
    output logic          any_req
);

    arb_state_e    state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] start;
    logic          accept;
    logic [N-1:0]  mask;
    logic [N-1:0]  masked_req;
    logic [IW-1:0] masked_idx;
    logic          masked_hit;
    logic [IW-1:0] full_idx;
    logic          full_hit;
    logic [IW-1:0] win_idx;

    function automatic logic [N-1:0] to_onehot(input logic [IW-1:0] k);
        to_onehot = '0;
        for (int i = 0; i < N; i++) begin
            to_onehot[i] = (int'(k) == i);
        end
    endfunction

    assign any_req = |req;
    assign accept  = (state == ARB_GRANT) && gnt_ack;

    // An accepted grant re-arbitrates in the same cycle, so search from the
    // pointer value it is about to write rather than the stale register.
    assign start = accept ? IW'(dec_mod(int'(gnt_idx), N)) : ptr;

    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i <= int'(start));
        end
    end

    assign masked_req = req & mask;

    prio_pick #(.N(N)) u_pick_masked (
        .req (masked_req),
        .idx (masked_idx),
        .hit (masked_hit)
    );

    prio_pick #(.N(N)) u_pick_full (
        .req (req),
        .idx (full_idx),
        .hit (full_hit)
    );

    // Masked search covers start..0; the unmasked pick supplies the wrap-around part
    assign win_idx = ((arb_mode_e'(mode) == ARB_RR) && masked_hit) ? masked_idx : full_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
            ptr        <= IW'(N - 1);
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (full_hit) begin
                        state      <= ARB_GRANT;
                        gnt_valid  <= 1'b1;
                        gnt_idx    <= win_idx;
                        gnt_onehot <= to_onehot(win_idx);
                    end
                end
                ARB_GRANT: begin
                    if (gnt_ack) begin
                        ptr <= start;
                        if (full_hit) begin
                            gnt_idx    <= win_idx;
                            gnt_onehot <= to_onehot(win_idx);
                        end else begin
                            state      <= ARB_IDLE;
                            gnt_valid  <= 1'b0;
                            gnt_onehot <= '0;
                        end
                    end
                end
                default: begin
                    state      <= ARB_IDLE;
                    gnt_valid  <= 1'b0;
                    gnt_onehot <= '0;
                end
            endcase
        end
    end

endmodule
